uart_rx: RTL and testbench

- 8N1 UART receiver for the SOC's RXD pin; the receiving counterpart of the SOC's UART transmitter on TXD.
- Oversamples the asynchronous RXD line with the system clock and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB-first and checks the stop bit.
- Presents each byte in a one-entry holding register that the CPU's IO read path consumes with a read strobe.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_if.sv | 34 +++
 rtl/sync_ff.sv | 25 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default baud timing.
// The transmitter imports the same baud constants so both ends agree on bit timing.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLK_HZ       = 100_000_000;
    localparam int UART_BAUD         = 115_200;
    localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;
    localparam int UART_SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    // Counter value at which the start bit is re-checked, roughly mid-bit.
    function automatic int halfBitCount(input int clksPerBit);
        return (clksPerBit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, holding register and sticky status out,
// plus the CPU read strobe that consumes the held byte.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      RXD;
    logic                      rd_strobe;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      frame_err;
    logic                      overrun;
    logic                      busy;

    modport master (
        output RXD,
        output rd_strobe,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  RXD,
        input  rd_strobe,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

endinterface

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for a single asynchronous input.
// The reset value lets an idle-high line come out of reset without a false edge.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-entry holding register and
// sticky framing/overrun flags cleared by the CPU read strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = UART_SYNC_STAGES
) (
    input  logic      CLK,
    input  logic      RESET,
    uart_rx_if.slave  bus
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(halfBitCount(CLKS_PER_BIT));
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t               r_state;
    logic [CW-1:0]             r_cnt;
    logic [2:0]                r_bitIdx;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      r_ovr;

    logic w_rxs;
    logic w_stopTick;
    logic w_goodStop;
    logic w_badStop;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (CLK),
        .rst (RESET),
        .i_d (bus.RXD),
        .o_q (w_rxs)
    );

    assign w_stopTick = (r_state == STOP) && (r_cnt == LAST);
    assign w_goodStop = w_stopTick && w_rxs;
    assign w_badStop  = w_stopTick && !w_rxs;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shreg  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            // A read coinciding with a load hands the CPU the new byte and clears nothing.
            if (w_goodStop) begin
                if (!r_valid || bus.rd_strobe) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (bus.rd_strobe) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
                r_ferr  <= 1'b0;
            end
            if (w_badStop) begin
                r_ferr <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == HALF) begin
                        r_cnt    <= '0;
                        r_bitIdx <= '0;
                        r_state  <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rxs, r_shreg[UART_DATA_BITS-1:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= w_rxs ? IDLE : BREAK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    // Hold off start detection until the line has recovered from a break.
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an event-scheduled model predicts outputs from
// frame timing, and a per-cycle compare checks every output against it.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
    localparam int HALF = (CPB - 1) / 2;
    // Edges from the edge before RXD falls to the edge that loads the byte.
    localparam int LAT         = SYNC + HALF + 9 * CPB + 2;
    localparam int BUSY_ON_DLY = SYNC + 1;
    localparam int GLITCH_OFF  = SYNC + 1 + HALF + 1;
    localparam int BREAK_OFF   = SYNC + 1;

    typedef enum int {EV_BUSY_ON, EV_BUSY_OFF, EV_GOOD, EV_FERR, EV_RD} evKind_t;
    typedef struct {
        int unsigned at;
        evKind_t     kind;
        logic [7:0]  data;
        int          gen;
    } event_t;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    int unsigned cyc   = 0;

    uart_rx_if bus();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    event_t     evQ[$];
    int         gen      = 0;
    int         checks   = 0;
    int         failures = 0;
    bit         simDone  = 1'b0;
    logic [7:0] mData    = 8'h00;
    logic       mValid   = 1'b0;
    logic       mFerr    = 1'b0;
    logic       mOvr     = 1'b0;
    logic       mBusy    = 1'b0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%02h expected=0x%02h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic pushEvent(input int unsigned at, input evKind_t kind, input logic [7:0] data);
        event_t e;
        e.at   = at;
        e.kind = kind;
        e.data = data;
        e.gen  = gen;
        evQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic compareLoop();
        logic       gotGood;
        logic       gotFerr;
        logic       gotRd;
        logic [7:0] newByte;
        while (!simDone) begin
            @(negedge CLK);
            if (RESET) begin
                mData  = 8'h00;
                mValid = 1'b0;
                mFerr  = 1'b0;
                mOvr   = 1'b0;
                mBusy  = 1'b0;
            end else begin
                gotGood = 1'b0;
                gotFerr = 1'b0;
                gotRd   = 1'b0;
                newByte = 8'h00;
                foreach (evQ[i]) begin
                    if (evQ[i].gen == gen && evQ[i].at == cyc) begin
                        case (evQ[i].kind)
                            EV_BUSY_ON:  mBusy = 1'b1;
                            EV_BUSY_OFF: mBusy = 1'b0;
                            EV_GOOD:     begin gotGood = 1'b1; newByte = evQ[i].data; end
                            EV_FERR:     gotFerr = 1'b1;
                            EV_RD:       gotRd = 1'b1;
                            default:     ;
                        endcase
                    end
                end
                if (gotGood) begin
                    if (!mValid || gotRd) begin
                        mData  = newByte;
                        mValid = 1'b1;
                    end else begin
                        mOvr = 1'b1;
                    end
                end else if (gotRd) begin
                    mValid = 1'b0;
                    mOvr   = 1'b0;
                    mFerr  = 1'b0;
                end
                if (gotFerr) mFerr = 1'b1;
                checkOutput("cmp_rx_data", bus.rx_data, mData);
                checkOutput("cmp_rx_valid", {7'd0, bus.rx_valid}, {7'd0, mValid});
                checkOutput("cmp_frame_err", {7'd0, bus.frame_err}, {7'd0, mFerr});
                checkOutput("cmp_overrun", {7'd0, bus.overrun}, {7'd0, mOvr});
                checkOutput("cmp_busy", {7'd0, bus.busy}, {7'd0, mBusy});
            end
        end
    endtask

    // Called just after a rising edge; RXD falls before the next edge.
    task automatic sendFrame(input logic [7:0] b, input int stopBits, input logic stopVal);
        int unsigned n;
        n = cyc;
        pushEvent(n + BUSY_ON_DLY, EV_BUSY_ON, 8'h00);
        if (stopVal) begin
            pushEvent(n + LAT, EV_GOOD, b);
            pushEvent(n + LAT, EV_BUSY_OFF, 8'h00);
        end else begin
            pushEvent(n + LAT, EV_FERR, 8'h00);
            pushEvent(n + (9 + stopBits) * CPB + BREAK_OFF, EV_BUSY_OFF, 8'h00);
        end
        bus.RXD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.RXD = b[i];
            tick(CPB);
        end
        bus.RXD = stopVal;
        tick(CPB * stopBits);
        bus.RXD = 1'b1;
    endtask

    task automatic pulseRead();
        bus.rd_strobe = 1'b1;
        pushEvent(cyc + 1, EV_RD, 8'h00);
        tick(1);
        bus.rd_strobe = 1'b0;
    endtask

    task automatic applyStimulus();
        int unsigned n;
        bus.RXD       = 1'b1;
        bus.rd_strobe = 1'b0;
        RESET         = 1'b1;
        tick(3);
        RESET = 1'b0;
        tick(2);
        checkOutput("reset_rx_data", bus.rx_data, 8'h00);
        checkOutput("reset_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
        checkOutput("reset_frame_err", {7'd0, bus.frame_err}, 8'h00);
        checkOutput("reset_overrun", {7'd0, bus.overrun}, 8'h00);
        checkOutput("reset_busy", {7'd0, bus.busy}, 8'h00);

        $display("[TB] byte 0xA5");
        fork
            sendFrame(8'hA5, 1, 1'b1);
            begin
                tick(78);
                checkOutput("a5_valid_before_load", {7'd0, bus.rx_valid}, 8'h00);
                tick(1);
                checkOutput("a5_valid_at_load", {7'd0, bus.rx_valid}, 8'h01);
                checkOutput("a5_rx_data", bus.rx_data, 8'hA5);
            end
        join
        checkOutput("a5_frame_err", {7'd0, bus.frame_err}, 8'h00);
        checkOutput("a5_overrun", {7'd0, bus.overrun}, 8'h00);
        pulseRead();
        checkOutput("a5_valid_after_read", {7'd0, bus.rx_valid}, 8'h00);

        $display("[TB] start-bit glitch");
        n = cyc;
        pushEvent(n + BUSY_ON_DLY, EV_BUSY_ON, 8'h00);
        pushEvent(n + GLITCH_OFF, EV_BUSY_OFF, 8'h00);
        bus.RXD = 1'b0;
        tick(2);
        bus.RXD = 1'b1;
        tick(2 * CPB);
        checkOutput("glitch_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
        checkOutput("glitch_frame_err", {7'd0, bus.frame_err}, 8'h00);
        checkOutput("glitch_busy", {7'd0, bus.busy}, 8'h00);

        $display("[TB] byte 0x3C with long break");
        fork
            sendFrame(8'h3C, 20, 1'b0);
            begin
                tick(150);
                checkOutput("break_busy", {7'd0, bus.busy}, 8'h01);
                checkOutput("break_frame_err", {7'd0, bus.frame_err}, 8'h01);
            end
        join
        tick(CPB);
        checkOutput("break_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
        checkOutput("break_busy_after", {7'd0, bus.busy}, 8'h00);
        sendFrame(8'h81, 1, 1'b1);
        tick(2);
        checkOutput("b81_rx_data", bus.rx_data, 8'h81);
        checkOutput("b81_frame_err_sticky", {7'd0, bus.frame_err}, 8'h01);
        pulseRead();
        checkOutput("b81_frame_err_cleared", {7'd0, bus.frame_err}, 8'h00);

        $display("[TB] back-to-back overrun");
        sendFrame(8'h11, 1, 1'b1);
        sendFrame(8'h22, 1, 1'b1);
        tick(2);
        checkOutput("ovr_rx_data", bus.rx_data, 8'h11);
        checkOutput("ovr_overrun", {7'd0, bus.overrun}, 8'h01);
        pulseRead();
        checkOutput("ovr_cleared", {7'd0, bus.overrun}, 8'h00);
        sendFrame(8'h11, 1, 1'b1);
        fork
            sendFrame(8'h22, 1, 1'b1);
            begin
                tick(LAT - 1);
                pulseRead();
            end
        join
        tick(2);
        checkOutput("rdload_rx_data", bus.rx_data, 8'h22);
        checkOutput("rdload_rx_valid", {7'd0, bus.rx_valid}, 8'h01);
        checkOutput("rdload_overrun", {7'd0, bus.overrun}, 8'h00);

        $display("[TB] reset during bit 4 of 0xFF");
        n = cyc;
        pushEvent(n + BUSY_ON_DLY, EV_BUSY_ON, 8'h00);
        bus.RXD = 1'b0;
        tick(CPB);
        bus.RXD = 1'b1;
        tick(4 * CPB + 4);
        #2;
        RESET = 1'b1;
        gen++;
        #1;
        checkOutput("abort_rx_data", bus.rx_data, 8'h00);
        checkOutput("abort_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
        checkOutput("abort_busy", {7'd0, bus.busy}, 8'h00);
        tick(3);
        RESET = 1'b0;
        tick(2);
        sendFrame(8'h5A, 1, 1'b1);
        tick(2);
        checkOutput("b5a_rx_data", bus.rx_data, 8'h5A);
        checkOutput("b5a_rx_valid", {7'd0, bus.rx_valid}, 8'h01);
        tick(4);
        simDone = 1'b1;
    endtask

    initial begin
        fork
            compareLoop();
            applyStimulus();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
